// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mul_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Memory stage wins when both later stages write the same register.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic [3:0] wa3m,
                                         input logic [3:0] wa3w, input logic rwm,
                                         input logic rww);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rwm && (ra == wa3m)) begin
      sel = FWD_M;
    end else if (rww && (ra == wa3w)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mul_seq.sv
// Multiply occupancy sequencer: tracks how long a multiply holds the Execute stage.
module mul_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  output logic hold,
  output logic MulBusy,
  output logic MulDoneE
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MUL_CYCLES - 2);
  // A two-cycle multiply has no BUSY phase: start cycle then straight to DONE.
  localparam bit Direct = (MUL_CYCLES == 2);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_ok;

  assign start_ok = MulStartE && (state_q != StBusy);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (MulStartE) begin
          state_d = Direct ? StDone : StBusy;
          cnt_d   = CntLoad;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StDone;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hold     = start_ok || (state_q == StBusy);
  assign MulBusy  = !reset && ((state_q == StBusy) || (state_q == StDone));
  assign MulDoneE = !reset && (state_q == StDone);

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding selects, stage stalls and flushes for the five-stage core.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Ra1D,
  input  logic [3:0] Ra2D,
  input  logic [3:0] Ra1E,
  input  logic [3:0] Ra2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusy,
  output logic       MulDoneE
);

  logic hold;
  logic ldr_stall;
  logic pc_wr_pending;

  mul_seq #(
    .MUL_CYCLES(MUL_CYCLES),
    .CNT_W     (CNT_W)
  ) u_mul_seq (
    .clk      (clk),
    .reset    (reset),
    .MulStartE(MulStartE),
    .hold     (hold),
    .MulBusy  (MulBusy),
    .MulDoneE (MulDoneE)
  );

  assign ForwardAE = fwd_sel(Ra1E, WA3M, WA3W, RegWriteM, RegWriteW);
  assign ForwardBE = fwd_sel(Ra2E, WA3M, WA3W, RegWriteM, RegWriteW);

  assign ldr_stall     = MemtoRegE && ((Ra1D == WA3E) || (Ra2D == WA3E));
  assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

  // A multiply in Execute freezes F/D/E and bubbles M, overriding other hazards.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (hold) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else begin
      StallF = ldr_stall || pc_wr_pending;
      StallD = ldr_stall;
      FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
      FlushE = ldr_stall || BranchTakenE;
    end
  end

endmodule
